// File: rtl/pad_ctrl_pkg.sv
// pad_ctrl_pkg
//   Shared definitions for the pad control / input filter slice.
//   - CNT_WIDTH_DEFAULT   : default width of the debounce threshold and counters
//   - SYNC_STAGES_DEFAULT : default depth of the input synchronizer chain
//   - pad_cfg_t           : per-pad control bundle {dir, out, pen}
package pad_ctrl_pkg;

   localparam int unsigned CNT_WIDTH_DEFAULT   = 8;
   localparam int unsigned SYNC_STAGES_DEFAULT = 2;

   // dir: 1 = pad drives, out: value driven, pen: pull-enable request
   typedef struct packed {
      logic dir;
      logic out;
      logic pen;
   } pad_cfg_t;

endpackage

// File: rtl/pad_debounce.sv
// pad_debounce
//   Input path for one pad: synchronizer chain into the core clock domain,
//   followed by a counter-based glitch filter producing a stable level and
//   single-cycle rise/fall events.
// Ports:
//   clk_i          core clock
//   rst_ni         asynchronous active-low reset
//   cfg_debounce_i threshold N; level changes after N+1 consecutive differing cycles
//   pad_o_i        raw asynchronous pad input
//   in_o           filtered stable level
//   rise_o/fall_o  one-cycle pulses, coincident with in_o taking the new value
module pad_debounce
   import pad_ctrl_pkg::*;
#(
   parameter int unsigned SyncStages = SYNC_STAGES_DEFAULT,
   parameter int unsigned CntWidth   = CNT_WIDTH_DEFAULT
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [CntWidth-1:0] cfg_debounce_i,
   input  logic                pad_o_i,
   output logic                in_o,
   output logic                rise_o,
   output logic                fall_o
);

   logic [SyncStages-1:0] sync_q, sync_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic                  level_q, level_d;
   logic                  rise_q, rise_d;
   logic                  fall_q, fall_d;
   logic                  sync_s;

   // Shift the raw pad value through the chain; the last flop is the
   // first one considered metastability-safe.
   assign sync_d = {sync_q[SyncStages-2:0], pad_o_i};
   assign sync_s = sync_q[SyncStages-1];

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q >= cfg_debounce_i) begin
         // The >= (not ==) lets a lowered threshold take effect at once and
         // keeps the counter from ever reaching its wrap point.
         level_d = sync_s;
         cnt_d   = '0;
         rise_d  = sync_s;
         fall_d  = ~sync_s;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign in_o   = level_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/pad_ctrl_filter.sv
// pad_ctrl_filter
//   Per-pin control stage next to the functional pad cells. Registers the
//   output-enable / drive / pull values going to each pad and filters each
//   pad's input into a stable level plus rise/fall events.
// Ports:
//   clk_i, rst_ni      core clock, asynchronous active-low reset
//   cfg_debounce_i     shared debounce threshold N (0 = 1-cycle pass-through)
//   dir_i/out_i/pen_i  per-pad direction, drive value, pull-enable request
//   pad_oen_o          registered ~dir_i (1 = high-Z)
//   pad_i_o            registered out_i
//   pad_pen_o          registered pen_i
//   pad_o_i            raw pad inputs
//   in_o/rise_o/fall_o filtered level and edge events per pad
module pad_ctrl_filter
   import pad_ctrl_pkg::*;
#(
   parameter int unsigned NumPads    = 1,
   parameter int unsigned SyncStages = SYNC_STAGES_DEFAULT,
   parameter int unsigned CntWidth   = CNT_WIDTH_DEFAULT
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [CntWidth-1:0] cfg_debounce_i,
   input  logic [NumPads-1:0]  dir_i,
   input  logic [NumPads-1:0]  out_i,
   input  logic [NumPads-1:0]  pen_i,
   output logic [NumPads-1:0]  pad_oen_o,
   output logic [NumPads-1:0]  pad_i_o,
   output logic [NumPads-1:0]  pad_pen_o,
   input  logic [NumPads-1:0]  pad_o_i,
   output logic [NumPads-1:0]  in_o,
   output logic [NumPads-1:0]  rise_o,
   output logic [NumPads-1:0]  fall_o
);

   // Control values are stored as given (dir, not oen) so that the all-zero
   // reset value naturally means "every pad high-Z".
   pad_cfg_t [NumPads-1:0] ctrl_q, ctrl_d;

   for (genvar gi = 0; gi < NumPads; gi++) begin : g_pad
      assign ctrl_d[gi].dir = dir_i[gi];
      assign ctrl_d[gi].out = out_i[gi];
      assign ctrl_d[gi].pen = pen_i[gi];

      assign pad_oen_o[gi] = ~ctrl_q[gi].dir;
      assign pad_i_o[gi]   = ctrl_q[gi].out;
      assign pad_pen_o[gi] = ctrl_q[gi].pen;

      // The input path always filters the pad, even while it drives, so a
      // driven pad loops its own value back.
      pad_debounce #(
         .SyncStages (SyncStages),
         .CntWidth   (CntWidth)
      ) u_debounce (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .cfg_debounce_i (cfg_debounce_i),
         .pad_o_i        (pad_o_i[gi]),
         .in_o           (in_o[gi]),
         .rise_o         (rise_o[gi]),
         .fall_o         (fall_o[gi])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

endmodule

// File: doc/pad_ctrl_filter.md
# pad_ctrl_filter

Per-pin control stage sitting directly upstream/downstream of the FPGA functional pad cells. It registers the output-enable, output-data and pull-enable values driven into each pad. It also brings each pad's input value into the core clock domain through a synchronizer. The synchronized value then passes a programmable glitch/debounce filter that emits a stable level plus single-cycle rise/fall events. GPIO and peripheral muxing logic consume the filtered level and events; they never see raw pad inputs.

## Interface
Parameters:
- NumPads, 1, number of pads handled (vector width of all per-pad ports)
- SyncStages, 2, flip-flops in input synchronizer chain (legal ≥2)
- CntWidth, 8, width of debounce threshold and per-pad counter

Ports:
- clk_i  input  1  core clock; the only clock of the block
- rst_ni  input  1  asynchronous, active-low reset
- cfg_debounce_i  input  CntWidth  debounce threshold N, shared by all pads; 0 = no filtering
- dir_i  input  NumPads  1 = pad drives (output), 0 = pad is input
- out_i  input  NumPads  data to drive when dir_i=1
- pen_i  input  NumPads  pull-enable request
- pad_oen_o  output  NumPads  to pad OEN; 1 = high-Z/input
- pad_i_o  output  NumPads  to pad I (drive value)
- pad_pen_o  output  NumPads  to pad PEN
- pad_o_i  input  NumPads  from pad O (raw, asynchronous)
- in_o  output  NumPads  filtered, stable input level
- rise_o  output  NumPads  1-cycle pulse on filtered 0→1
- fall_o  output  NumPads  1-cycle pulse on filtered 1→0

## Operation
- Output path is registered: pad_oen_o <= ~dir_i, pad_i_o <= out_i, pad_pen_o <= pen_i.
- Reset values: pad_oen_o all 1 (every pad high-Z), pad_i_o 0, pad_pen_o 0, in_o 0, rise_o 0, fall_o 0, synchronizer flops 0, counters 0.
- Input path per pad: pad_o_i → SyncStages flops → sync value s.
- The filter holds stable level q (= in_o) and counter cnt.
- Each cycle, one of three rules applies:
  - s == q: cnt <= 0.
  - s != q and cnt >= cfg_debounce_i: q <= s, cnt <= 0, and the matching rise/fall pulse fires.
  - Otherwise: cnt <= cnt+1.
- Consequence: q changes only after s has differed from q for N+1 consecutive cycles. A glitch of ≤N cycles at s is rejected. N=0 passes s through with 1 cycle delay.
- cnt never exceeds max(cfg_debounce_i, previous cnt). No wrap is possible, because the >= comparison takes over before the counter saturates.
- cfg_debounce_i changes take effect immediately. If the new N is ≤ the current cnt, the update fires on the next cycle where s != q.
- rise_o and fall_o are mutually exclusive per pad and registered; they are high in the same cycle in_o first shows the new value.
- A pad high at reset release produces a rise_o once the filter settles, because in_o resets to 0. Consumers treat the first event after reset accordingly.
- Loopback: when dir_i=1 the input path still filters the pad's own driven value; no masking is applied.
- Reset asserted mid-count: all state clears asynchronously and no pulse is emitted.

## Timing
- Output path latency: 1 cycle from dir_i/out_i/pen_i to pad_*_o.
- Input path latency, pad_o_i edge to in_o change: SyncStages + N + 1 cycles (±1 for asynchronous sampling).
- No combinational path from any input to any output.

## Structure
- Shared package pad_ctrl_pkg holds:
  - the CntWidth default;
  - a per-pad config struct {dir, out, pen} for users bundling the control inputs.
- Sub-module pad_debounce contains the filter for one pad (synchronizer chain, counter, q, edge pulses). The top instantiates NumPads copies and adds the output register bank.

## Test plan
- Reset: rst_ni low → pad_oen_o all 1, pad_i_o/pad_pen_o/in_o/rise_o/fall_o all 0. Release with pad_o_i=1, N=3 → rise_o pulses exactly at cycle SyncStages+4, and in_o=1 from that cycle.
- Output path: dir_i=1, out_i=1, pen_i=1 at cycle t → pad_oen_o=0, pad_i_o=1, pad_pen_o=1 at t+1.
- Glitch rejection: N=4 with a 4-cycle high pulse at s → no in_o change and no pulses. A 5-cycle pulse → in_o goes 1 with one rise_o, then returns 0 with one fall_o.
- Bypass: N=0, toggle pad_o_i every 3 cycles → in_o follows with latency SyncStages+1, and each toggle produces exactly one rise_o or fall_o.
- Threshold change mid-count: N=10, s differs for 6 cycles, then N set to 2 → in_o updates on the next cycle.
- Asynchronous reset during count: N=8, assert rst_ni at cnt=5 → counters and in_o clear without waiting for clk_i. After release no pulse fires until a full N+1-cycle run completes.
